sipo_frame_ctrl: RTL and testbench

Sequences loading of one operand vector (weight row or activation column) into a sipo buffer that feeds the systolic array edge. It accepts a ready/valid beat stream with a last flag, and zero-pads short frames to exactly depth_p entries. It presents the completed frame to the array-side consumer and holds it until the consumer takes it. It also owns the sipo buffer's synchronous pointer reset and provides a full zero-clear, because the buffer does not zero its storage on reset.

---
 rtl/sipo_frame_ctrl_if.sv | 35 +++
 rtl/sipo_frame_ctrl.sv | 109 ++++++++++
 tb/tb_sipo_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_ctrl_if.sv
// Handshake bundle between the frame controller, its upstream beat source,
// the sipo buffer write port and the array-side frame consumer.
interface sipo_frame_ctrl_if #(
    parameter int width_p = 8,
    parameter int depth_p = 128
);
    localparam int fill_w_lp = $clog2(depth_p + 1);

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [width_p-1:0]   in_data_i;
    logic                 in_last_i;
    logic                 clear_i;
    logic                 sipo_reset_o;
    logic                 sipo_valid_o;
    logic [width_p-1:0]   sipo_data_o;
    logic                 frame_valid_o;
    logic                 frame_yumi_i;
    logic [fill_w_lp-1:0] fill_count_o;
    logic                 busy_o;

    // Controller side.
    modport slave (
        input  in_valid_i, in_data_i, in_last_i, clear_i, frame_yumi_i,
        output in_ready_o, sipo_reset_o, sipo_valid_o, sipo_data_o,
               frame_valid_o, fill_count_o, busy_o
    );

    // Environment side: beat source, buffer and consumer together.
    modport master (
        output in_valid_i, in_data_i, in_last_i, clear_i, frame_yumi_i,
        input  in_ready_o, sipo_reset_o, sipo_valid_o, sipo_data_o,
               frame_valid_o, fill_count_o, busy_o
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Fills one depth_p-entry sipo frame from a ready/valid beat stream, zero-pads
// short frames, holds the frame for the consumer and owns the buffer's clear.
module sipo_frame_ctrl #(
    parameter int width_p = 8,
    parameter int depth_p = 128
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    sipo_frame_ctrl_if.slave bus
);
    localparam int cnt_w_lp  = $clog2(depth_p);
    localparam int fill_w_lp = $clog2(depth_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(depth_p - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_FILL,
        S_PAD,
        S_HOLD,
        S_CLRRST,
        S_CLEAR
    } state_e;

    state_e                state_q, state_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
    logic [fill_w_lp-1:0]  fill_q, fill_d;
    logic                  cnt_last;
    logic                  accept;
    logic                  clear_take;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    assign cnt_last   = (cnt_q == cnt_max_lp);
    assign clear_take = bus.clear_i && (state_q != S_CLRRST) && (state_q != S_CLEAR);
    assign accept     = (state_q == S_FILL) && bus.in_valid_i && !bus.clear_i;

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no
        // path through the case below can leave one unassigned and infer a latch.
        state_d           = state_q;
        cnt_d             = cnt_q;
        fill_d            = fill_q;
        bus.in_ready_o    = 1'b0;
        bus.sipo_reset_o  = 1'b0;
        bus.sipo_valid_o  = 1'b0;
        bus.sipo_data_o   = '0;
        bus.frame_valid_o = 1'b0;

        case (state_q)
            S_INIT: begin
                bus.sipo_reset_o = 1'b1;
                cnt_d            = '0;
                fill_d           = '0;
                state_d          = S_FILL;
            end
            S_FILL: begin
                bus.in_ready_o = !bus.clear_i;
                if (accept) begin
                    bus.sipo_valid_o = 1'b1;
                    bus.sipo_data_o  = bus.in_data_i;
                    cnt_d            = cnt_q + 1'b1;
                    fill_d           = fill_q + 1'b1;
                    // The last slot closes the frame even without in_last_i.
                    if (cnt_last)          state_d = S_HOLD;
                    else if (bus.in_last_i) state_d = S_PAD;
                end
            end
            S_PAD: begin
                bus.sipo_valid_o = 1'b1;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_last) state_d = S_HOLD;
            end
            S_HOLD: begin
                bus.frame_valid_o = 1'b1;
                if (bus.frame_yumi_i) state_d = S_INIT;
            end
            S_CLRRST: begin
                bus.sipo_reset_o = 1'b1;
                cnt_d            = '0;
                state_d          = S_CLEAR;
            end
            S_CLEAR: begin
                bus.sipo_valid_o = 1'b1;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_last) state_d = S_INIT;
            end
            default: state_d = S_INIT;
        endcase

        // Clear outranks accept and yumi; an aborted frame's beats are dropped.
        if (clear_take) begin
            state_d = S_CLRRST;
            fill_d  = '0;
        end
    end

    assign bus.fill_count_o = fill_q;
    assign bus.busy_o       = (state_q != S_FILL);
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural frame model.
module tb_sipo_frame_ctrl;
    localparam int W = 8;
    localparam int D = 4;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;

    sipo_frame_ctrl_if #(.width_p(W), .depth_p(D)) bus ();

    sipo_frame_ctrl #(.width_p(W), .depth_p(D)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame phase tracked as pending events and countdowns.
    bit           m_init    = 1'b1;
    bit           m_clrrst  = 1'b0;
    bit           m_hold    = 1'b0;
    int           m_pad     = 0;
    int           m_clear   = 0;
    int           m_fill    = 0;
    logic [W-1:0] m_frame[$];
    logic [W-1:0] sbuf[D];
    int           sptr      = 0;
    bit           zero_chk  = 1'b0;
    bit           hold_seen = 1'b0;

    always @(negedge clk_i) begin
        logic         e_rst, e_rdy, e_val, e_fv, e_busy;
        logic [W-1:0] e_dat;
        logic [W-1:0] e_ent;

        if (!reset_ni) begin
            m_init = 1'b1; m_clrrst = 1'b0; m_hold = 1'b0;
            m_pad = 0; m_clear = 0; m_fill = 0;
            m_frame.delete();
            zero_chk = 1'b0; hold_seen = 1'b0;
        end

        e_rst = 1'b0; e_rdy = 1'b0; e_val = 1'b0; e_fv = 1'b0; e_busy = 1'b1; e_dat = '0;
        if (m_init || m_clrrst) begin
            e_rst = 1'b1;
        end else if (m_clear > 0 || m_pad > 0) begin
            e_val = 1'b1;
        end else if (m_hold) begin
            e_fv = 1'b1;
        end else begin
            e_busy = 1'b0;
            e_rdy  = !bus.clear_i;
            e_val  = bus.in_valid_i && !bus.clear_i;
            if (e_val) e_dat = bus.in_data_i;
        end

        check("m_sipo_reset",  bus.sipo_reset_o,  e_rst);
        check("m_in_ready",    bus.in_ready_o,    e_rdy);
        check("m_sipo_valid",  bus.sipo_valid_o,  e_val);
        check("m_sipo_data",   bus.sipo_data_o,   e_dat);
        check("m_frame_valid", bus.frame_valid_o, e_fv);
        check("m_busy",        bus.busy_o,        e_busy);
        check("m_fill_count",  bus.fill_count_o,  m_fill);

        if (m_hold && !hold_seen) begin
            hold_seen = 1'b1;
            for (int i = 0; i < D; i++) begin
                e_ent = (i < m_frame.size()) ? m_frame[i] : '0;
                check("frame_entry", sbuf[i], e_ent);
            end
        end
        if (zero_chk) begin
            zero_chk = 1'b0;
            for (int i = 0; i < D; i++) check("cleared_entry", sbuf[i], 0);
        end

        // Emulated sipo buffer fed by the controller's write port.
        if (bus.sipo_reset_o) begin
            sptr = 0;
        end else if (bus.sipo_valid_o) begin
            sbuf[sptr] = bus.sipo_data_o;
            sptr = (sptr + 1) % D;
        end

        if (reset_ni) begin
            if (m_clrrst) begin
                m_clrrst = 1'b0;
                m_clear  = D;
            end else if (m_clear > 0) begin
                m_clear--;
                if (m_clear == 0) begin
                    m_init   = 1'b1;
                    zero_chk = 1'b1;
                end
            end else if (bus.clear_i) begin
                m_init = 1'b0; m_pad = 0; m_hold = 1'b0; hold_seen = 1'b0;
                m_clrrst = 1'b1; m_fill = 0;
                m_frame.delete();
            end else if (m_init) begin
                m_init = 1'b0;
                m_fill = 0;
                m_frame.delete();
            end else if (m_pad > 0) begin
                m_pad--;
                if (m_pad == 0) m_hold = 1'b1;
            end else if (m_hold) begin
                if (bus.frame_yumi_i) begin
                    m_hold = 1'b0; hold_seen = 1'b0; m_init = 1'b1;
                end
            end else if (bus.in_valid_i) begin
                m_frame.push_back(bus.in_data_i);
                m_fill++;
                if (m_fill == D)         m_hold = 1'b1;
                else if (bus.in_last_i)  m_pad  = D - m_fill;
            end
        end
    end

    task automatic idle();
        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = '0;
        bus.in_last_i    = 1'b0;
        bus.clear_i      = 1'b0;
        bus.frame_yumi_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (!bus.in_ready_o && k < 50) begin
            step();
            k++;
        end
        check(name, bus.in_ready_o, 1);
    endtask

    initial begin
        idle();
        reset_ni = 1'b0;
        repeat (3) step();
        #1;
        check("rst_sipo_reset",  bus.sipo_reset_o,  1);
        check("rst_in_ready",    bus.in_ready_o,    0);
        check("rst_busy",        bus.busy_o,        1);
        check("rst_fill_count",  bus.fill_count_o,  0);
        check("rst_frame_valid", bus.frame_valid_o, 0);
        check("rst_sipo_valid",  bus.sipo_valid_o,  0);

        step();
        reset_ni = 1'b1;
        #1;
        check("init_sipo_reset", bus.sipo_reset_o, 1);
        check("init_in_ready",   bus.in_ready_o,   0);
        step(); #1;
        check("fill_in_ready",   bus.in_ready_o,   1);
        check("fill_sipo_reset", bus.sipo_reset_o, 0);

        // Full frame, no last flag.
        for (int i = 0; i < D; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = W'(8'hA0 + i);
            #1;
            check("full_wr_valid", bus.sipo_valid_o, 1);
            check("full_wr_data",  bus.sipo_data_o,  8'hA0 + i);
            step();
        end
        idle(); #1;
        check("full_frame_valid", bus.frame_valid_o, 1);
        check("full_fill_count",  bus.fill_count_o,  4);
        check("full_no_pad",      bus.sipo_valid_o,  0);
        check("full_in_ready",    bus.in_ready_o,    0);

        repeat (5) begin
            step(); #1;
            check("hold_frame_valid", bus.frame_valid_o, 1);
        end
        bus.frame_yumi_i = 1'b1;
        step();
        bus.frame_yumi_i = 1'b0;
        #1;
        check("yumi_init_reset", bus.sipo_reset_o, 1);
        step();
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'hE0;
        #1;
        check("e_in_ready", bus.in_ready_o,   1);
        check("e_write",    bus.sipo_valid_o, 1);
        step();
        idle(); #1;
        check("e_fill_count", bus.fill_count_o, 1);

        // Clear coincident with a valid beat, one beat into the frame.
        bus.clear_i    = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'hF0;
        #1;
        check("clr_in_ready", bus.in_ready_o,   0);
        check("clr_no_write", bus.sipo_valid_o, 0);
        step();
        idle(); #1;
        check("clrrst_reset", bus.sipo_reset_o, 1);
        check("clrrst_fill",  bus.fill_count_o, 0);
        for (int i = 0; i < D; i++) begin
            step(); #1;
            check("clr_zero_valid",  bus.sipo_valid_o,  1);
            check("clr_zero_data",   bus.sipo_data_o,   0);
            check("clr_frame_valid", bus.frame_valid_o, 0);
        end
        step(); #1;
        check("clr_init_reset", bus.sipo_reset_o, 1);
        step(); #1;
        check("after_clr_ready", bus.in_ready_o,   1);
        check("after_clr_fill",  bus.fill_count_o, 0);

        // Short frame: two beats, last on the second.
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'hA1;
        step();
        bus.in_data_i  = 8'hB2;
        bus.in_last_i  = 1'b1;
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            check("pad_valid",    bus.sipo_valid_o, 1);
            check("pad_data",     bus.sipo_data_o,  0);
            check("pad_in_ready", bus.in_ready_o,   0);
            step();
        end
        #1;
        check("short_frame_valid", bus.frame_valid_o, 1);
        check("short_fill_count",  bus.fill_count_o,  2);

        // Clear and yumi together while holding.
        bus.clear_i      = 1'b1;
        bus.frame_yumi_i = 1'b1;
        step();
        idle(); #1;
        check("prio_clrrst_reset", bus.sipo_reset_o,  1);
        check("prio_frame_valid",  bus.frame_valid_o, 0);
        check("prio_fill_count",   bus.fill_count_o,  0);
        wait_ready("prio_recover");

        // Async reset while padding.
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'hC3;
        bus.in_last_i  = 1'b1;
        step();
        idle(); #1;
        check("apad_valid", bus.sipo_valid_o, 1);
        reset_ni = 1'b0;
        #1;
        check("areset_valid",      bus.sipo_valid_o, 0);
        check("areset_sipo_reset", bus.sipo_reset_o, 1);
        check("areset_fill",       bus.fill_count_o, 0);
        repeat (2) begin
            step(); #1;
            check("areset_no_write", bus.sipo_valid_o, 0);
        end
        step();
        reset_ni = 1'b1;
        wait_ready("areset_recover");

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid_i   = ($urandom_range(0, 3) != 0);
            bus.in_data_i    = W'($urandom);
            bus.in_last_i    = ($urandom_range(0, 3) == 0);
            bus.frame_yumi_i = ($urandom_range(0, 2) == 0);
            bus.clear_i      = ($urandom_range(0, 39) == 0);
            reset_ni         = ($urandom_range(0, 799) != 0);
            step();
        end
        idle();
        reset_ni = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
